// File: rtl/ones_comp_seq_div.sv
// One's-complement sequential divider: 30-bit double-word dividend by a 15-bit
// divisor. Restoring algorithm producing one quotient bit per clock, with a
// start/busy/done handshake. Quotient and remainder are 15-bit 1's-comp words.
module ones_comp_seq_div (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [29:0] numer,
  input  logic [14:0] denom,
  output logic        busy,
  output logic        done,
  output logic [14:0] quot,
  output logic [14:0] remain,
  output logic        div_error
);

  localparam int unsigned NUM_BIT   = 15;
  localparam int unsigned MAG_BIT   = NUM_BIT - 1;
  localparam int unsigned CNT_W     = 4;
  localparam int unsigned LAST_ITER = MAG_BIT - 1;

  localparam logic [NUM_BIT-1:0] QUOT_ERR_NEG = 15'o40000;
  localparam logic [NUM_BIT-1:0] QUOT_ERR_POS = 15'o37777;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    ITER  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [NUM_BIT-1:0]   hi_q, hi_d;
  logic [NUM_BIT-1:0]   lo_q, lo_d;
  logic [NUM_BIT-1:0]   den_q, den_d;
  logic [MAG_BIT-1:0]   dmag_q, dmag_d;
  logic [MAG_BIT-1:0]   rem_q, rem_d;
  logic [MAG_BIT-1:0]   shf_q, shf_d;
  logic [MAG_BIT-1:0]   qb_q, qb_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 sq_q, sq_d;
  logic                 sn_q, sn_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [NUM_BIT-1:0]   quot_q, quot_d;
  logic [NUM_BIT-1:0]   remain_q, remain_d;
  logic                 err_q, err_d;

  logic [MAG_BIT-1:0]   hi_mag_c, lo_mag_c, den_mag_c;
  logic                 sn_c, sq_c, check_err_c;
  logic [MAG_BIT:0]     r_shift_c;
  logic                 ge_c;
  logic [MAG_BIT-1:0]   r_next_c;
  logic [MAG_BIT-1:0]   q_next_c;

  // Sign/magnitude form of a 1's-comp word: negative words are bit-inverted.
  function automatic logic [NUM_BIT-1:0] enc(input logic s, input logic [MAG_BIT-1:0] m);
    return {s, s ? ~m : m};
  endfunction

  // Operand magnitudes, result signs and error detection from the latched operands.
  always_comb begin
    hi_mag_c    = hi_q[MAG_BIT]  ? ~hi_q[MAG_BIT-1:0]  : hi_q[MAG_BIT-1:0];
    lo_mag_c    = lo_q[MAG_BIT]  ? ~lo_q[MAG_BIT-1:0]  : lo_q[MAG_BIT-1:0];
    den_mag_c   = den_q[MAG_BIT] ? ~den_q[MAG_BIT-1:0] : den_q[MAG_BIT-1:0];
    sn_c        = (hi_mag_c != '0) ? hi_q[MAG_BIT] :
                  (lo_mag_c != '0) ? lo_q[MAG_BIT] : 1'b0;
    sq_c        = sn_c ^ den_q[MAG_BIT];
    check_err_c = (den_mag_c == '0) ||
                  (hi_mag_c >= den_mag_c) ||
                  ((hi_mag_c != '0) && (lo_mag_c != '0) && (hi_q[MAG_BIT] != lo_q[MAG_BIT]));
  end

  // One restoring-division step: shift in the next dividend bit, subtract if it fits.
  always_comb begin
    r_shift_c = {rem_q, shf_q[MAG_BIT-1]};
    ge_c      = (r_shift_c >= {1'b0, dmag_q});
    r_next_c  = ge_c ? MAG_BIT'(r_shift_c - {1'b0, dmag_q}) : r_shift_c[MAG_BIT-1:0];
    q_next_c  = {qb_q[MAG_BIT-2:0], ge_c};
  end

  // Next-state and datapath/output updates.
  always_comb begin
    state_d  = state_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    den_d    = den_q;
    dmag_d   = dmag_q;
    rem_d    = rem_q;
    shf_d    = shf_q;
    qb_d     = qb_q;
    cnt_d    = cnt_q;
    sq_d     = sq_q;
    sn_d     = sn_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    quot_d   = quot_q;
    remain_d = remain_q;
    err_d    = err_q;

    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (start) begin
          hi_d    = numer[2*NUM_BIT-1:NUM_BIT];
          lo_d    = numer[NUM_BIT-1:0];
          den_d   = denom;
          err_d   = 1'b0;
          busy_d  = 1'b1;
          state_d = CHECK;
        end
      end
      CHECK: begin
        sq_d   = sq_c;
        sn_d   = sn_c;
        dmag_d = den_mag_c;
        if (check_err_c) begin
          quot_d   = sq_c ? QUOT_ERR_NEG : QUOT_ERR_POS;
          remain_d = '0;
          err_d    = 1'b1;
          done_d   = 1'b1;
          state_d  = DONE;
        end else begin
          rem_d   = hi_mag_c;
          shf_d   = lo_mag_c;
          qb_d    = '0;
          cnt_d   = '0;
          state_d = ITER;
        end
      end
      ITER: begin
        rem_d = r_next_c;
        shf_d = {shf_q[MAG_BIT-2:0], 1'b0};
        qb_d  = q_next_c;
        cnt_d = CNT_W'(cnt_q + 1'b1);
        if (cnt_q == CNT_W'(LAST_ITER)) begin
          quot_d   = enc(sq_q, q_next_c);
          remain_d = enc(sn_q, r_next_c);
          done_d   = 1'b1;
          state_d  = DONE;
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset abandons any divide in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      hi_q     <= '0;
      lo_q     <= '0;
      den_q    <= '0;
      dmag_q   <= '0;
      rem_q    <= '0;
      shf_q    <= '0;
      qb_q     <= '0;
      cnt_q    <= '0;
      sq_q     <= 1'b0;
      sn_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      quot_q   <= '0;
      remain_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      den_q    <= den_d;
      dmag_q   <= dmag_d;
      rem_q    <= rem_d;
      shf_q    <= shf_d;
      qb_q     <= qb_d;
      cnt_q    <= cnt_d;
      sq_q     <= sq_d;
      sn_q     <= sn_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      quot_q   <= quot_d;
      remain_q <= remain_d;
      err_q    <= err_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign quot      = quot_q;
  assign remain    = remain_q;
  assign div_error = err_q;

endmodule

// File: tb/tb_ones_comp_seq_div.sv
// Bench for ones_comp_seq_div: directed spec cases, handshake and reset
// scenarios, then randomized divides against an arithmetic reference model.
module tb_ones_comp_seq_div;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [29:0] numer;
  logic [14:0] denom;
  logic        busy;
  logic        done;
  logic [14:0] quot;
  logic [14:0] remain;
  logic        div_error;

  int checks = 0;
  int errors = 0;

  logic [14:0] last_q;
  logic [14:0] last_r;

  logic [29:0] rn;
  logic [14:0] rd;
  int unsigned rdm, rhm, rlm;
  logic        rs, rds;
  int          ndone;

  ones_comp_seq_div dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .numer     (numer),
    .denom     (denom),
    .busy      (busy),
    .done      (done),
    .quot      (quot),
    .remain    (remain),
    .div_error (div_error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0o expected=%0o", tag, obs, exp);
    end
  endtask

  // Signed magnitude value to a 15-bit 1's-comp word: negation is 2^15-1 minus m.
  function automatic logic [14:0] to_oc(input logic s, input int unsigned m);
    return s ? 15'(32'd32767 - m) : 15'(m);
  endfunction

  // Magnitude of a 15-bit 1's-comp word.
  function automatic int unsigned mag_of(input logic [14:0] w);
    int unsigned v;
    v = 32'(w);
    return (v >= 32'd16384) ? 32'd32767 - v : v;
  endfunction

  // Reference: integer division of |high|*2^14+|low| by |denom| with sign rules.
  function automatic void model(input logic [29:0] n, input logic [14:0] d,
                                output logic [14:0] q, output logic [14:0] r,
                                output logic err);
    int unsigned hm, lm, dm, big;
    logic hs, ls, sn, sq;
    logic [14:0] hw, lw;
    hw = n[29:15];
    lw = n[14:0];
    hs = hw[14];
    ls = lw[14];
    hm = mag_of(hw);
    lm = mag_of(lw);
    dm = mag_of(d);
    sn = (hm != 0) ? hs : ((lm != 0) ? ls : 1'b0);
    sq = sn ^ d[14];
    err = (dm == 0) || (hm >= dm) || ((hm != 0) && (lm != 0) && (hs != ls));
    if (err) begin
      q = sq ? 15'o40000 : 15'o37777;
      r = 15'o00000;
    end else begin
      big = hm * 32'd16384 + lm;
      q = to_oc(sq, big / dm);
      r = to_oc(sn, big % dm);
    end
  endfunction

  // Runs one divide starting at the current negedge; mode 1 injects ignored starts.
  task automatic do_div(input logic [29:0] n, input logic [14:0] d, input int mode);
    logic [14:0] eq, er;
    logic ee;
    int lat;
    int extra;
    bit seen;
    model(n, d, eq, er, ee);
    numer = n;
    denom = d;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", 32'(busy), 32'd1);
    chk("err_cleared_at_start", 32'(div_error), 32'd0);
    chk("quot_held_at_start", 32'(quot), 32'(last_q));
    chk("remain_held_at_start", 32'(remain), 32'(last_r));
    lat = 1;
    seen = 1'b0;
    while (!seen && lat < 40) begin
      if (done) begin
        seen = 1'b1;
      end else begin
        if (mode == 1 && lat == 5) begin
          numer = ~n;
          denom = 15'o00001;
          start = 1'b1;
        end else begin
          start = 1'b0;
        end
        @(negedge clk);
        lat++;
      end
    end
    start = 1'b0;
    chk("done_seen", 32'(seen), 32'd1);
    chk("latency", 32'(lat), ee ? 32'd2 : 32'd16);
    chk("busy_in_done", 32'(busy), 32'd1);
    chk("quot", 32'(quot), 32'(eq));
    chk("remain", 32'(remain), 32'(er));
    chk("div_error", 32'(div_error), 32'(ee));
    last_q = eq;
    last_r = er;
    if (mode == 1) begin
      numer = 30'o1234567;
      denom = 15'o00002;
      start = 1'b1;
    end
    @(negedge clk);
    start = 1'b0;
    chk("done_one_cycle", 32'(done), 32'd0);
    chk("busy_after_done", 32'(busy), 32'd0);
    if (mode == 1) begin
      extra = 0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (done) extra++;
      end
      chk("no_extra_done", 32'(extra), 32'd0);
      chk("quot_hold_idle", 32'(quot), 32'(eq));
      chk("busy_idle", 32'(busy), 32'd0);
    end
  endtask

  initial begin
    rst    = 1'b1;
    start  = 1'b0;
    numer  = '0;
    denom  = '0;
    last_q = '0;
    last_r = '0;

    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_quot", 32'(quot), 32'd0);
    chk("rst_remain", 32'(remain), 32'd0);
    chk("rst_err", 32'(div_error), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Directed cases from the datasheet examples, issued back to back.
    do_div({15'o00001, 15'o00000}, 15'o00003, 0);
    chk("basic_quot_lit", 32'(quot), 32'o12525);
    chk("basic_rem_lit", 32'(remain), 32'o00001);
    do_div({15'o77776, 15'o77777}, 15'o00003, 0);
    chk("neg_quot_lit", 32'(quot), 32'o65252);
    chk("neg_rem_lit", 32'(remain), 32'o77776);
    do_div(30'o0, 15'o00005, 0);
    chk("zero_quot_lit", 32'(quot), 32'o00000);
    do_div({15'o00001, 15'o00000}, 15'o77777, 0);
    chk("dz_quot_lit", 32'(quot), 32'o40000);
    do_div({15'o00005, 15'o00000}, 15'o00005, 0);
    chk("ovf_quot_lit", 32'(quot), 32'o37777);
    do_div({15'o00001, 15'o77770}, 15'o00003, 0);
    chk("mixed_err_lit", 32'(div_error), 32'd1);
    do_div({15'o00000, 15'o77777}, 15'o00007, 0);
    do_div({15'o00000, 15'o40000}, 15'o77770, 0);
    do_div({15'o00002, 15'o12345}, 15'o77774, 0);

    // Starts while busy and in the DONE cycle are ignored.
    do_div({15'o00001, 15'o00000}, 15'o00003, 1);

    // Reset mid-divide abandons it with no done.
    numer = {15'o00002, 15'o00000};
    denom = 15'o00005;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_quot", 32'(quot), 32'd0);
    chk("midrst_remain", 32'(remain), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    last_q = '0;
    last_r = '0;
    ndone = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("midrst_no_done", 32'(ndone), 32'd0);
    do_div({15'o00001, 15'o00000}, 15'o00003, 0);

    // Randomized divides, biased toward non-error operands.
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        rn = 30'($urandom);
        rd = 15'($urandom);
      end else begin
        rdm = $urandom_range(1, 16383);
        rhm = $urandom_range(0, rdm - 1);
        rlm = $urandom_range(0, 16383);
        rs  = 1'($urandom_range(0, 1));
        rds = 1'($urandom_range(0, 1));
        rn  = {to_oc(rs, rhm), to_oc(rs, rlm)};
        rd  = to_oc(rds, rdm);
      end
      do_div(rn, rd, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
